// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit controller that owns the architectural HI/LO pair.
// Results are computed combinationally from latched operands and committed when the countdown expires.
module mdu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        md_op,
  input  logic              req,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              hilo_busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] a_p1, b_p1;
  logic [2:0]        op_p1;

  logic accept_p0, muldiv_p0, commit_p1, op_is_mul_p1;
  logic [2*DATA_W-1:0] mul_res_p1, div_res_p1;

  // Full-width product; operands are sign- or zero-extended so one multiplier covers both forms.
  function automatic logic [2*DATA_W-1:0] mul_full(input logic is_signed,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] ea, eb, p;
    ea = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
    eb = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
    p  = ea * eb;
    return p;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so the most-negative
  // dividend divided by -1 wraps to itself instead of overflowing.
  function automatic logic [2*DATA_W-1:0] div_full(input logic is_signed,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic neg_a, neg_b;
    logic [DATA_W-1:0] ua, ub, uq, ur, q, r;
    neg_a = is_signed & a[DATA_W-1];
    neg_b = is_signed & b[DATA_W-1];
    ua = neg_a ? -a : a;
    ub = neg_b ? -b : b;
    uq = ua / ub;
    ur = ua % ub;
    q  = (neg_a ^ neg_b) ? -uq : uq;
    r  = neg_a ? -ur : ur;
    return {r, q};
  endfunction

  // Stage p0: issue decision on the E-stage instruction
  assign muldiv_p0 = (md_op != 3'd0) && (md_op <= 3'd4);
  assign accept_p0 = start && !req && (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign hilo_busy = busy || (accept_p0 && muldiv_p0 && !reset);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_p0 && muldiv_p0) begin
          state_d = RUN;
          cnt_d   = (md_op <= OP_MULTU) ? 4'd5 : 4'd10;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: latched operands feed the result functions; commit on the last RUN cycle
  assign op_is_mul_p1 = (op_p1 == OP_MULT) || (op_p1 == OP_MULTU);
  assign commit_p1    = (state_q == RUN) && (cnt_q == 4'd1);
  assign mul_res_p1   = mul_full(op_p1 == OP_MULT, a_p1, b_p1);
  assign div_res_p1   = div_full(op_p1 == OP_DIV, a_p1, b_p1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      a_p1    <= '0;
      b_p1    <= '0;
      op_p1   <= 3'd0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_p0 && muldiv_p0) begin
        a_p1  <= rs_val;
        b_p1  <= rt_val;
        op_p1 <= md_op;
      end
      if (accept_p0 && md_op == OP_MTHI) hi <= rs_val;
      if (accept_p0 && md_op == OP_MTLO) lo <= rs_val;
      if (commit_p1) begin
        if (op_is_mul_p1) begin
          {hi, lo} <= mul_res_p1;
        end else if (b_p1 != '0) begin
          {hi, lo} <= div_res_p1;
        end
      end
    end
  end

endmodule
